// File: rtl/multi_timer.sv
// multi_timer: 64-bit prescaled time base with NumChannels compare channels and IRQs; define MULTI_TIMER_PERIODIC_EN for periodic CMP reload
module multi_timer #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int NumChannels   = 4,
  parameter int PrescaleWidth = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [3:0]              timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [31:0]             timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [31:0]             timer_rdata_o,
  output logic                    timer_err_o,
  output logic                    timer_intr_o,
  output logic [NumChannels-1:0]  chan_intr_o
);
  if (DataWidth != 32) begin : g_dw_check
    $error("multi_timer supports DataWidth=32 only");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_nch_check
    $error("multi_timer NumChannels must be 1..8");
  end
  logic [7:0] off;
  logic [3:0] ch;
  logic [1:0] sub;
  logic [31:0] mask;
  logic [31:0] rd;
  logic ch_ok;
  logic err_c;
  logic wr;
  logic tick;
  logic unused_addr;
  logic [63:0] mtime;
  logic [PrescaleWidth-1:0] prescale;
  logic [PrescaleWidth-1:0] pcnt;
  logic en;
  logic [NumChannels-1:0] pend;
  logic [NumChannels-1:0] ien;
  logic [NumChannels-1:0] match;
  logic [NumChannels-1:0] chan_sel;
  logic [NumChannels-1:0][63:0] cmp;
`ifdef MULTI_TIMER_PERIODIC_EN
  logic [NumChannels-1:0][31:0] period;
  logic [NumChannels-1:0] periodic;
`endif
  assign off = timer_addr_i[9:2];
  assign ch = off[5:2];
  assign sub = off[1:0];
  assign mask = {{8{timer_be_i[3]}}, {8{timer_be_i[2]}}, {8{timer_be_i[1]}}, {8{timer_be_i[0]}}};
  assign ch_ok = off[7:6] == 2'b01 && {1'b0, ch} < 5'(NumChannels);
  assign err_c = !(ch_ok || off <= 8'h05);
  assign wr = timer_req_i && timer_we_i && !err_c;
  assign tick = en && pcnt == prescale;
  assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};
  assign chan_intr_o = pend & ien;
  assign timer_intr_o = |chan_intr_o;

  function automatic logic [31:0] merge(input logic [31:0] o);
    return (o & ~mask) | (timer_wdata_i & mask);
  endfunction

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    assign match[i] = mtime >= cmp[i];
    assign chan_sel[i] = wr && ch_ok && ch == 4'(i);
  end

  // time base: prescaler and 64-bit counter; a bus write to either half suppresses that cycle's increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime <= '0;
      pcnt <= '0;
      prescale <= '0;
      en <= 1'b0;
    end else begin
      if (wr && off == 8'h02) begin
        prescale <= PrescaleWidth'(merge(32'(prescale)));
        pcnt <= '0;
      end else if (tick) pcnt <= '0;
      else if (en) pcnt <= pcnt + PrescaleWidth'(1);
      if (wr && off == 8'h03 && timer_be_i[0]) en <= timer_wdata_i[0];
      if (wr && off == 8'h00) mtime[31:0] <= merge(mtime[31:0]);
      else if (wr && off == 8'h01) mtime[63:32] <= merge(mtime[63:32]);
      else if (tick) mtime <= mtime + 64'd1;
    end
  end

  // pending bits: a match in the same cycle as a write-1-to-clear keeps the bit set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= '0;
      ien <= '0;
    end else begin
      pend <= (pend & ~(wr && off == 8'h04 ? timer_wdata_i[NumChannels-1:0] & mask[NumChannels-1:0] : '0)) | match;
      if (wr && off == 8'h05) ien <= NumChannels'(merge(32'(ien)));
    end
  end

  // channel registers: compare values (plus period/mode when periodic reload is built in)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp <= '1;
`ifdef MULTI_TIMER_PERIODIC_EN
      period <= '0;
      periodic <= '0;
`endif
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
`ifdef MULTI_TIMER_PERIODIC_EN
        if (match[n] && periodic[n] && !(chan_sel[n] && !sub[1])) cmp[n] <= cmp[n] + 64'(period[n]);
        if (chan_sel[n] && sub == 2'd2) period[n] <= merge(period[n]);
        if (chan_sel[n] && sub == 2'd3 && timer_be_i[0]) periodic[n] <= timer_wdata_i[0];
`endif
        if (chan_sel[n] && sub == 2'd0) cmp[n][31:0] <= merge(cmp[n][31:0]);
        if (chan_sel[n] && sub == 2'd1) cmp[n][63:32] <= merge(cmp[n][63:32]);
      end
    end
  end

  // read data mux; reserved bits and unimplemented registers read 0
  always_comb begin
    rd = '0;
    case (off)
      8'h00: rd = mtime[31:0];
      8'h01: rd = mtime[63:32];
      8'h02: rd = 32'(prescale);
      8'h03: rd = {31'd0, en};
      8'h04: rd = 32'(pend);
      8'h05: rd = 32'(ien);
      default: rd = '0;
    endcase
    for (int n = 0; n < NumChannels; n++) begin
`ifdef MULTI_TIMER_PERIODIC_EN
      if (ch_ok && ch == 4'(n)) rd = sub == 2'd0 ? cmp[n][31:0] : sub == 2'd1 ? cmp[n][63:32] : sub == 2'd2 ? period[n] : {31'd0, periodic[n]};
`else
      if (ch_ok && ch == 4'(n)) rd = sub == 2'd0 ? cmp[n][31:0] : sub == 2'd1 ? cmp[n][63:32] : 32'd0;
`endif
    end
  end

  // bus response, one cycle after every request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_rvalid_o <= 1'b0;
      timer_err_o <= 1'b0;
      timer_rdata_o <= '0;
    end else begin
      timer_rvalid_o <= timer_req_i;
      timer_err_o <= timer_req_i && err_c;
      timer_rdata_o <= timer_req_i && !timer_we_i && !err_c ? rd : '0;
    end
  end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: reset table, corner sequences and randomized runs against an arithmetic reference model
module tb_multi_timer;
  localparam int NCH = 4;
  localparam logic [31:0] A_LO = 32'h00, A_HI = 32'h04, A_PRE = 32'h08, A_CTRL = 32'h0C, A_PEND = 32'h10, A_IEN = 32'h14;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [3:0] be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic rvalid;
  logic err;
  logic tintr;
  logic [31:0] rdata;
  logic [NCH-1:0] cintr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_timer #(.NumChannels(NCH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .timer_req_i(req), .timer_we_i(we), .timer_be_i(be),
    .timer_addr_i(addr), .timer_wdata_i(wdata), .timer_rvalid_o(rvalid), .timer_rdata_o(rdata),
    .timer_err_o(err), .timer_intr_o(tintr), .chan_intr_o(cintr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // called at a negedge; request is sampled at the next posedge, response checked at the following negedge
  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] r, output logic e);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    be = b;
    @(negedge clk);
    req = 1'b0;
    we = 1'b0;
    chk("rvalid", rvalid, 1);
    r = rdata;
    e = err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    acc(1'b1, a, d, 4'hF, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    acc(1'b0, a, 32'd0, 4'hF, r, e);
    chk({name, "_err"}, e, 0);
    chk(name, r, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[14];
    logic [31:0] r;
    logic e;
    tbl = '{
      '{32'h000, 32'h0, 1'b0}, '{32'h004, 32'h0, 1'b0}, '{32'h008, 32'h0, 1'b0},
      '{32'h00C, 32'h0, 1'b0}, '{32'h010, 32'h0, 1'b0}, '{32'h014, 32'h0, 1'b0},
      '{32'h100, 32'hFFFFFFFF, 1'b0}, '{32'h104, 32'hFFFFFFFF, 1'b0},
      '{32'h108, 32'h0, 1'b0}, '{32'h13C, 32'h0, 1'b0},
      '{32'h018, 32'h0, 1'b1}, '{32'h180, 32'h0, 1'b1},
      '{32'h140, 32'h0, 1'b1}, '{32'h3FC, 32'h0, 1'b1}
    };
    idle(3);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_cintr", cintr, 0);
    chk("rst_tintr", tintr, 0);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 14; i++) begin
      acc(1'b0, tbl[i].addr, 32'd0, 4'hF, r, e);
      chk($sformatf("tbl_rdata_%0h", tbl[i].addr), r, tbl[i].data);
      chk($sformatf("tbl_err_%0h", tbl[i].addr), e, tbl[i].err);
      idle(1);
      chk("rvalid_drop", rvalid, 0);
    end
    // prescale 3 for 40 enabled cycles
    wr(A_PRE, 3);
    wr(A_CTRL, 1);
    idle(39);
    wr(A_CTRL, 0);
    rd_chk("presc_lo", A_LO, 10);
    rd_chk("presc_hi", A_HI, 0);
    chk("presc_tintr", tintr, 0);
    // 64-bit wrap
    wr(A_LO, 32'hFFFFFFFE);
    wr(A_HI, 32'hFFFFFFFF);
    wr(A_PRE, 0);
    wr(A_CTRL, 1);
    idle(1);
    wr(A_CTRL, 0);
    rd_chk("wrap_lo0", A_LO, 0);
    rd_chk("wrap_hi0", A_HI, 0);
    wr(A_CTRL, 1);
    wr(A_CTRL, 0);
    rd_chk("wrap_lo1", A_LO, 1);
    rd_chk("wrap_hi1", A_HI, 0);
    // bus write to MTIME beats a simultaneous tick
    wr(A_HI, 32'h12);
    wr(A_LO, 0);
    wr(A_CTRL, 1);
    wr(A_LO, 5);
    wr(A_CTRL, 0);
    rd_chk("wwin_lo", A_LO, 6);
    rd_chk("wwin_hi", A_HI, 32'h12);
    // compare on channel 1 at 20
    wr(A_LO, 0);
    wr(A_HI, 0);
    wr(32'h110, 20);
    wr(32'h114, 0);
    wr(A_IEN, 2);
    wr(A_PEND, 32'hF);
    rd_chk("cmp_pend0", A_PEND, 0);
    wr(A_CTRL, 1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("cmp_cintr_k%0d", k), cintr, k >= 21 ? 4'b0010 : 4'b0000);
      chk($sformatf("cmp_tintr_k%0d", k), tintr, k >= 21 ? 1'b1 : 1'b0);
    end
    wr(A_PEND, 2);
    rd_chk("cmp_setwins", A_PEND, 2);
    wr(A_CTRL, 0);
    wr(32'h110, 32'hFFFFFFFF);
    wr(32'h114, 32'hFFFFFFFF);
    wr(A_PEND, 2);
    rd_chk("cmp_cleared", A_PEND, 0);
    chk("cmp_cintr_off", cintr, 0);
    chk("cmp_tintr_off", tintr, 0);
    // unmapped accesses
    acc(1'b1, 32'h3FC, 32'hFFFFFFFF, 4'hF, r, e);
    chk("unm_3fc_err", e, 1);
    acc(1'b1, 32'h180, 32'hFFFFFFFF, 4'hF, r, e);
    chk("unm_180_err", e, 1);
    acc(1'b0, 32'h180, 0, 4'hF, r, e);
    chk("unm_180_rerr", e, 1);
    chk("unm_180_rdata", r, 0);
    rd_chk("unm_ien", A_IEN, 2);
    rd_chk("unm_pre", A_PRE, 0);
    rd_chk("unm_ctrl", A_CTRL, 0);
    rd_chk("unm_cmp0", 32'h100, 32'hFFFFFFFF);
    // byte enables and reserved bits
    acc(1'b1, A_PRE, 32'h00000ABC, 4'h1, r, e);
    rd_chk("be_pre", A_PRE, 32'hBC);
    acc(1'b1, A_IEN, 32'hF, 4'h0, r, e);
    rd_chk("be_ien", A_IEN, 2);
    wr(A_PRE, 32'hFFFFFFFF);
    rd_chk("rsv_pre", A_PRE, 32'hFFF);
    wr(A_CTRL, 32'hFFFFFFFE);
    rd_chk("rsv_ctrl", A_CTRL, 0);
    wr(32'h108, 32'h1234);
`ifdef MULTI_TIMER_PERIODIC_EN
    rd_chk("period_rb", 32'h108, 32'h1234);
`else
    rd_chk("period_rb", 32'h108, 0);
`endif
    // randomized runs against the reference model
    for (int it = 0; it < 25; it++) begin
      logic [63:0] st;
      logic [63:0] fin;
      logic [63:0] cm [NCH];
      logic [NCH-1:0] ie;
      logic [NCH-1:0] pe;
      int p;
      int w;
      int ticks;
      st = {32'($urandom_range(0, 32'hFFFFFFFE)), 32'($urandom)};
      p = $urandom_range(0, 7);
      w = $urandom_range(0, 60);
      ticks = (w + 1) / (p + 1);
      fin = st + 64'(ticks);
      wr(A_CTRL, 0);
      wr(A_LO, st[31:0]);
      wr(A_HI, st[63:32]);
      wr(A_PRE, 32'(p));
      for (int n = 0; n < NCH; n++) begin
        cm[n] = st + 64'($urandom_range(1, 2 * ticks + 2));
        wr(32'h100 + 32'(16 * n), cm[n][31:0]);
        wr(32'h104 + 32'(16 * n), cm[n][63:32]);
        pe[n] = fin >= cm[n];
      end
      ie = NCH'($urandom);
      wr(A_IEN, 32'(ie));
      wr(A_PEND, 32'hF);
      wr(A_CTRL, 1);
      idle(w);
      wr(A_CTRL, 0);
      rd_chk($sformatf("rnd%0d_lo", it), A_LO, fin[31:0]);
      rd_chk($sformatf("rnd%0d_hi", it), A_HI, fin[63:32]);
      rd_chk($sformatf("rnd%0d_pend", it), A_PEND, 32'(pe));
      chk($sformatf("rnd%0d_cintr", it), cintr, pe & ie);
      chk($sformatf("rnd%0d_tintr", it), tintr, |(pe & ie));
    end
`ifdef MULTI_TIMER_PERIODIC_EN
    // periodic reload on channel 0
    wr(A_IEN, 0);
    wr(A_LO, 0);
    wr(A_HI, 0);
    wr(A_PRE, 0);
    wr(32'h100, 10);
    wr(32'h104, 0);
    wr(32'h108, 5);
    wr(32'h10C, 1);
    wr(A_PEND, 32'hF);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pv;
      wr(A_CTRL, 1);
      idle(k == 0 ? 11 : 4);
      wr(A_CTRL, 0);
      rd_chk($sformatf("per%0d_cmp_lo", k), 32'h100, 32'(15 + 5 * k));
      rd_chk($sformatf("per%0d_cmp_hi", k), 32'h104, 0);
      acc(1'b0, A_PEND, 0, 4'hF, pv, e);
      chk($sformatf("per%0d_pend_set", k), pv[0], 1);
      wr(A_PEND, 1);
      acc(1'b0, A_PEND, 0, 4'hF, pv, e);
      chk($sformatf("per%0d_pend_clr", k), pv[0], 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
